lcd_mmio_ctrl: RTL and testbench
================================

# lcd_mmio_ctrl

Memory-mapped HD44780-style character LCD controller for the CPU's peripheral window (address bit 31 set). CPU stores are queued as 9-bit {rs, data} entries in a write FIFO. A sequencer replays them onto the LCD pins with parametrised setup, enable-pulse, hold and post-command wait timing, so firmware no longer hand-toggles the enable line. A readable status register exposes FIFO level, busy and overflow state.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥2.
- SETUP_CYCLES, 2: cycles data/rs are stable before enable rises; ≥1.
- PULSE_CYCLES, 4: enable-high cycles; ≥1.
- HOLD_CYCLES, 2: cycles data/rs are held after enable falls; ≥1.
- CMD_WAIT_CYCLES, 40: idle gap after every entry; ≥0.
- CLEAR_WAIT_CYCLES, 1600: gap after a clear/home command (rs=0, data 0x01..0x03); ≥CMD_WAIT_CYCLES.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sel  in  1  peripheral select (decoded address bit 31).
- addr  in  4  byte offset within the block; bits [3:2] select the register.
- wdata  in  32  store data.
- wenable  in  4  byte write enables; a write takes effect only when sel && wenable[0].
- rdata  out  32  registered read data.
- lcd_data  out  8  LCD data bus.
- lcd_rs  out  1  register select (1 = character, 0 = command).
- lcd_rw  out  1  tied 0 (write only).
- lcd_enable  out  1  LCD strobe.
- busy  out  1  high while the FIFO is non-empty or the sequencer is not in IDLE.

## Operation
- Register map:
  - 0x0 DATA (W): push {1, wdata[7:0]}.
  - 0x4 CMD (W): push {0, wdata[7:0]}.
  - 0x8 STATUS (R): [0] busy, [1] empty, [2] full, [3] overflow, [15:8] level.
  - 0xC CTRL (W): bit0 flush FIFO, bit1 clear overflow.
- Any other access is ignored. Reads of offsets other than 0x8 return 0.
- Push while full (no pop in the same cycle): entry dropped, sticky overflow set. Push while full with a pop in the same cycle is accepted.
- Flush empties the FIFO. A transfer already in progress completes. A push in the same cycle as a flush is discarded without setting overflow.
- Sequencer FSM:
  - IDLE: if FIFO non-empty, pop the entry, latch lcd_data and lcd_rs, go to SETUP.
  - SETUP: runs SETUP_CYCLES with enable low, then PULSE.
  - PULSE: runs PULSE_CYCLES with enable high, then HOLD.
  - HOLD: runs HOLD_CYCLES with enable low, then WAIT.
  - WAIT: runs CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES for clear/home, then IDLE. A count of 0 skips WAIT.
- lcd_data and lcd_rs change only on the IDLE→SETUP transition.
- A single down-counter is sized to clog2 of the largest parameter plus 1.
- Reset values: lcd_data 0, lcd_rs 0, lcd_rw 0, lcd_enable 0, rdata 0, busy 0. FIFO is empty, overflow is 0, FSM is in IDLE.
- Reset mid-transfer aborts immediately; enable is low on the next cycle.

## Timing
- Store accepted at edge N: entry visible in level at N; pop and SETUP entry at N+1; lcd_enable rises at N+1+SETUP_CYCLES; falls PULSE_CYCLES later.
- Per-entry period: 1 + SETUP + PULSE + HOLD + wait cycles. Back-to-back entries always include the 1 IDLE cycle.
- rdata is valid the cycle after the read address is presented with sel high; it is 0 when sel is low.
- STATUS reflects state after the previous edge, so a push and a read in the same cycle show the pre-push level.

## Configuration
- LCD_CONSOLE_EN defined: on each falling edge of lcd_enable with lcd_rs=1, simulation prints the character (`$write("%c")`) to the console. This logic is non-synthesisable and is excluded from synthesis.
- LCD_CONSOLE_EN undefined: no print logic; pin behaviour is identical.

## Structure
- Package lcd_pkg holds:
  - Register offsets (DATA, CMD, STATUS, CTRL).
  - STATUS bit positions.
  - FSM state encoding (IDLE, SETUP, PULSE, HOLD, WAIT).
  - Entry width (9) and the clear/home command range.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push, pop, flush, full, empty, level, with synchronous active-high reset.

## Test plan
- Write DATA 0x41 after reset, defaults:
  - lcd_rs=1 and lcd_data=0x41 from N+1.
  - Enable high for exactly 4 cycles starting N+3.
  - busy drops at N+50.
- Write CMD 0x01:
  - lcd_rs=0; WAIT lasts 1600 cycles.
  - A following DATA entry's enable rises 1600+1+2 cycles after HOLD ends.
- With DEPTH=4, issue 6 DATA writes while the sequencer is stalled in WAIT:
  - The first entry is in flight; 4 more are queued and 1 is dropped.
  - STATUS reads full=1, overflow=1, level=4.
  - A CTRL write of 0x2 clears overflow.
- Flush with 3 queued entries during PULSE: current pulse completes, no further enables, STATUS empty=1, level=0.
- Assert rst while lcd_enable is high: the next cycle shows all outputs 0 and STATUS=0x0002 (empty only).
- LCD_CONSOLE_EN on, push "Hi" as DATA: console shows "Hi". With a command interleaved, the command prints nothing.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the memory-mapped character LCD controller:
// register map, status layout, sequencer states and FIFO entry format.
package lcd_pkg;

  localparam int ENTRY_W = 9;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CMD    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_BUSY      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_LEVEL_LSB = 8;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

  // Clear display / return home need the long post-command wait
  localparam logic [7:0] CLEAR_CMD_LO = 8'h01;
  localparam logic [7:0] CLEAR_CMD_HI = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  function automatic logic is_clear_home(lcd_entry_t e);
    return !e.rs && (e.data >= CLEAR_CMD_LO) && (e.data <= CLEAR_CMD_HI);
  endfunction

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; DEPTH must be a power of two. A push is
// accepted when full only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_mmio_ctrl.sv
// HD44780-style LCD controller: CPU stores are queued and replayed onto the
// LCD pins with programmed timing. Define LCD_CONSOLE_EN to echo characters.
module lcd_mmio_ctrl
  import lcd_pkg::*;
#(
  parameter int DEPTH             = 8,
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 4,
  parameter int HOLD_CYCLES       = 2,
  parameter int CMD_WAIT_CYCLES   = 40,
  parameter int CLEAR_WAIT_CYCLES = 1600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_enable,
  output logic        busy
);

  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int MAX_CYC = max2(max2(max2(SETUP_CYCLES, PULSE_CYCLES),
                                     max2(HOLD_CYCLES, CMD_WAIT_CYCLES)),
                                CLEAR_WAIT_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LD   =
    CNT_W'((CMD_WAIT_CYCLES > 0) ? CMD_WAIT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CLEAR_LD =
    CNT_W'((CLEAR_WAIT_CYCLES > 0) ? CLEAR_WAIT_CYCLES - 1 : 0);
  localparam logic CMD_SKIP   = (CMD_WAIT_CYCLES == 0);
  localparam logic CLEAR_SKIP = (CLEAR_WAIT_CYCLES == 0);

  lcd_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             clear_wait;
  logic             overflow;

  logic [1:0]       reg_sel;
  logic             wr_en;
  logic             push;
  logic             pop;
  logic             flush;
  logic             clr_ovf;
  lcd_entry_t       push_entry;
  lcd_entry_t       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             busy_now;
  logic [31:0]      status;
  logic             unused_bits;

  assign reg_sel    = addr[3:2];
  assign wr_en      = sel && wenable[0];
  assign push       = wr_en && ((reg_sel == REG_DATA) || (reg_sel == REG_CMD));
  assign push_entry = '{rs: (reg_sel == REG_DATA), data: wdata[7:0]};
  assign flush      = wr_en && (reg_sel == REG_CTRL) && wdata[CTRL_FLUSH];
  assign clr_ovf    = wr_en && (reg_sel == REG_CTRL) && wdata[CTRL_CLR_OVF];
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign busy_now   = !fifo_empty || (state != S_IDLE);
  assign lcd_rw     = 1'b0;
  assign unused_bits = ^{wenable[3:1], wdata[31:8], addr[1:0]};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (push_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    status                        = '0;
    status[ST_BUSY]               = busy_now;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_FULL]               = fifo_full;
    status[ST_OVF]                = overflow;
    status[ST_LEVEL_LSB +: 8]     = 8'(fifo_level);
  end

  // Bus side: registered read data, sticky overflow, registered busy
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rdata <= (sel && (reg_sel == REG_STATUS)) ? status : '0;
      busy  <= busy_now;
      if (push && fifo_full && !pop && !flush) overflow <= 1'b1;
      else if (clr_ovf)                        overflow <= 1'b0;
    end
  end

  // Sequencer: one down-counter shared by every timed phase
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      clear_wait <= 1'b0;
      lcd_data   <= '0;
      lcd_rs     <= 1'b0;
      lcd_enable <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            lcd_data   <= head.data;
            lcd_rs     <= head.rs;
            clear_wait <= is_clear_home(head);
            cnt        <= SETUP_LD;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            lcd_enable <= 1'b1;
            cnt        <= PULSE_LD;
            state      <= S_PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            lcd_enable <= 1'b0;
            cnt        <= HOLD_LD;
            state      <= S_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            if (clear_wait ? CLEAR_SKIP : CMD_SKIP) begin
              state <= S_IDLE;
            end else begin
              cnt   <= clear_wait ? CLEAR_LD : CMD_LD;
              state <= S_WAIT;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LCD_CONSOLE_EN
`ifndef SYNTHESIS
  always @(negedge lcd_enable) begin
    if (lcd_rs) $write("%c", lcd_data);
  end
`endif
`else
  // No console echo; pin behaviour is unchanged either way.
`endif

endmodule

// File: tb/tb_lcd_mmio_ctrl.sv
// Scoreboard bench for lcd_mmio_ctrl: queued entries are matched against
// each enable pulse, plus timing, status, flush, overflow and reset checks.
`timescale 1ns/1ps
module tb_lcd_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wenable = '0;
  logic [31:0] rdata;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_enable;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_rise = 0;
  int n_fall = 0;
  int last_rise = 0;
  int last_fall = 0;
  logic prev_en = 1'b0;
  logic [8:0] exp_q[$];

  lcd_mmio_ctrl #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .addr       (addr),
    .wdata      (wdata),
    .wenable    (wenable),
    .rdata      (rdata),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_enable (lcd_enable),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pulse monitor: each rising enable consumes one expected entry
  always @(negedge clk) begin
    if (lcd_enable && !prev_en) begin
      if (exp_q.size() == 0) check_eq("unexpected_pulse", {23'd0, lcd_rs, lcd_data}, 32'hFFFF_FFFF);
      else                   check_eq("entry", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_q.pop_front()});
      n_rise    <= n_rise + 1;
      last_rise <= cyc;
    end
    if (!lcd_enable && prev_en) begin
      n_fall    <= n_fall + 1;
      last_fall <= cyc;
      if (!rst) check_eq("pulse_width", cyc - last_rise, 4);
    end
    prev_en <= lcd_enable;
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; wenable = 4'hF;
    @(posedge clk); #1;
    sel = 1'b0; wenable = 4'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; addr = a; wenable = 4'h0;
    @(posedge clk); #1;
    sel = 1'b0;
    @(negedge clk);
    d = rdata;
  endtask

  task automatic push_data(input logic [7:0] c, input bit reaches_lcd);
    bus_write(4'h0, {24'd0, c});
    if (reaches_lcd) exp_q.push_back({1'b1, c});
  endtask

  task automatic wait_rises(input int target, input int limit, input string tag);
    int k = 0;
    while (n_rise < target && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_rise < target) check_eq(tag, n_rise, target);
  endtask

  task automatic wait_falls(input int target, input int limit, input string tag);
    int k = 0;
    while (n_fall < target && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_fall < target) check_eq(tag, n_fall, target);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int k = 0;
    @(negedge clk);
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (busy) check_eq(tag, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n0, r0, f0, fall_cmd;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_enable", lcd_enable, 0);
    check_eq("rst_data", lcd_data, 0);
    check_eq("rst_rs", lcd_rs, 0);
    check_eq("rst_rw", lcd_rw, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rdata", rdata, 0);
    rst = 1'b0;
    bus_read(4'h8, rd);
    check_eq("status_after_reset", rd, 32'h0000_0002);
    bus_read(4'h0, rd);
    check_eq("read_data_offset", rd, 32'h0);

    // Single DATA entry: latch, enable and busy timing
    push_data(8'h41, 1'b1);
    n0 = cyc;
    @(negedge clk);
    @(negedge clk);
    check_eq("t1_rs", lcd_rs, 1);
    check_eq("t1_data", lcd_data, 8'h41);
    check_eq("t1_busy", busy, 1);
    wait_rises(1, 20, "t1_rise_timeout");
    check_eq("t1_rise_cycle", last_rise, n0 + 3);
    wait_idle(100, "t1_idle_timeout");
    check_eq("t1_busy_drop_cycle", cyc, n0 + 50);

    // Clear command followed by data: long wait before the next enable
    r0 = n_rise;
    f0 = n_fall;
    bus_write(4'h4, 32'h0000_0001);
    exp_q.push_back(9'h001);
    push_data(8'h42, 1'b1);
    wait_falls(f0 + 1, 100, "t2_fall_timeout");
    fall_cmd = last_fall;
    check_eq("t2_cmd_rs", lcd_rs, 0);
    wait_rises(r0 + 2, 2000, "t2_rise_timeout");
    check_eq("t2_clear_gap", last_rise - fall_cmd, 1605);
    wait_idle(200, "t2_idle_timeout");

    // Overflow: one in flight, four queued, sixth dropped
    for (int i = 0; i < 5; i++) push_data(8'h50 + 8'(i), 1'b1);
    push_data(8'h55, 1'b0);
    bus_read(4'h8, rd);
    check_eq("t3_status_full_ovf", rd, 32'h0000_040D);
    bus_write(4'hC, 32'h2);
    bus_read(4'h8, rd);
    check_eq("t3_status_ovf_clr", rd, 32'h0000_0405);
    wait_idle(400, "t3_idle_timeout");
    check_eq("t3_queue_drained", exp_q.size(), 0);

    // Flush during a pulse: current transfer completes, rest discarded
    r0 = n_rise;
    f0 = n_fall;
    push_data(8'h60, 1'b1);
    for (int i = 1; i < 4; i++) push_data(8'h60 + 8'(i), 1'b0);
    wait_rises(r0 + 1, 20, "t4_rise_timeout");
    bus_write(4'hC, 32'h1);
    wait_idle(100, "t4_idle_timeout");
    check_eq("t4_rises", n_rise, r0 + 1);
    check_eq("t4_falls", n_fall, f0 + 1);
    bus_read(4'h8, rd);
    check_eq("t4_status", rd, 32'h0000_0002);

    // Reset while enable is high
    r0 = n_rise;
    push_data(8'h77, 1'b1);
    wait_rises(r0 + 1, 20, "t5_rise_timeout");
    @(negedge clk);
    check_eq("t5_enable_high", lcd_enable, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_enable", lcd_enable, 0);
    check_eq("t5_data", lcd_data, 0);
    check_eq("t5_rs", lcd_rs, 0);
    check_eq("t5_rw", lcd_rw, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_read(4'h8, rd);
    check_eq("t5_status", rd, 32'h0000_0002);
    repeat (20) @(negedge clk);
    check_eq("final_queue_empty", exp_q.size(), 0);
    check_eq("final_no_pulse", n_rise, r0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule
